// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
// State encoding, store-size codes and address width.
package hazard_ctrl_pkg;

  localparam int PIPE_REG_AW = 5;

  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RMW   = 2'd1,
    S_MWAIT = 2'd2
  } state_t;

  // Down-counter width able to hold max(a, b); never below one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares the ID source registers against the EX destination.
// Only ports whose operand is actually read may match.
module hazard_src_match
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = PIPE_REG_AW
) (
  input  logic [NUM_SRC*REG_AW-1:0] i_rs,
  input  logic [NUM_SRC-1:0]        i_used,
  input  logic [REG_AW-1:0]         i_rd,
  output logic                      o_match
);

  // OR-reduce the per-port equality over the used ports.
  always_comb begin
    o_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_used[i] && (i_rs[i*REG_AW +: REG_AW] == i_rd)) begin
        o_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, sub-word store RMW,
// data-memory wait states and branch redirect.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = PIPE_REG_AW,
  parameter int NUM_SRC  = 2,
  parameter int RMW_LAT  = 1,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_ex_mem_read,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_mem_access,
  input  logic                      ex_mem_wen,
  input  logic [1:0]                ex_mem_mask_mode,
  input  logic                      ex_mem_mem_read,
  input  logic                      ex_taken,
  output logic                      pc_from_taken,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_stall,
  output logic                      ex_mem_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int CW = cnt_width(RMW_LAT, MEM_WAIT);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] RMW_INIT = CW'(RMW_LAT - 1);
  localparam logic [CW-1:0] MW_INIT =
    CW'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_match;
  logic w_lu;
  logic w_rmw;
  logic w_mw;

  logic w_pc_from_taken;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_id_ex_stall;
  logic w_ex_mem_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;
  logic w_busy;

  hazard_src_match #(
    .NUM_SRC (NUM_SRC),
    .REG_AW  (REG_AW)
  ) u_src_match (
    .i_rs    (id_rs),
    .i_used  (id_rs_used),
    .i_rd    (id_ex_rd),
    .o_match (w_match)
  );

  // Raw hazard conditions; x0 never creates a load-use.
  always_comb begin
    w_lu  = id_ex_mem_read && (id_ex_rd != '0) && w_match;
    w_rmw = id_ex_mem_access && ex_mem_wen &&
            (ex_mem_mask_mode != MASK_WORD);
    w_mw  = (MEM_WAIT > 0) && ex_mem_mem_read;
  end

  // Control decode: wait > redirect > RMW > load-use in idle.
  always_comb begin
    w_pc_from_taken = 1'b0;
    w_pc_stall      = 1'b0;
    w_if_id_stall   = 1'b0;
    w_id_ex_stall   = 1'b0;
    w_ex_mem_stall  = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_flush  = 1'b0;
    w_busy          = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mw) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
          end else if (ex_taken) begin
            w_pc_from_taken = 1'b1;
            w_if_id_flush   = 1'b1;
            w_id_ex_flush   = 1'b1;
          end else if (w_rmw) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_flush = 1'b1;
          end else if (w_lu) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_flush = 1'b1;
          end
        end
        S_RMW: begin
          w_busy         = 1'b1;
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_flush = 1'b1;
        end
        S_MWAIT: begin
          w_busy         = 1'b1;
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Multi-cycle sequencer; cnt holds stall cycles still to go.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mw) begin
            if (MEM_WAIT > 1) begin
              r_state <= S_MWAIT;
              r_cnt   <= MW_INIT;
            end
          end else if (!ex_taken && w_rmw && (RMW_LAT > 1)) begin
            r_state <= S_RMW;
            r_cnt   <= RMW_INIT;
          end
        end
        S_RMW, S_MWAIT: begin
          if (r_cnt <= ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_pc_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pc_from_taken = w_pc_from_taken;
  assign pc_stall      = w_pc_stall;
  assign if_id_stall   = w_if_id_stall;
  assign id_ex_stall   = w_id_ex_stall;
  assign ex_mem_stall  = w_ex_mem_stall;
  assign if_id_flush   = w_if_id_flush;
  assign id_ex_flush   = w_id_ex_flush;
  assign ex_mem_flush  = w_ex_mem_flush;
  assign busy          = w_busy;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of ID source-register ports checked (1..3).
REQ-003 SHALL have parameter RMW_LAT, default 1, stall cycles per sub-word store read-modify-write (>=1).
REQ-004 SHALL have parameter MEM_WAIT, default 0, data-memory wait cycles per load (0..15).
REQ-005 SHALL have parameter CNT_W, default 32, stall-counter width.
REQ-006 SHALL have ports, in this order:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  NUM_SRC*REG_AW  ID source addresses; port i at bits [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  per-port "operand actually read".
- id_ex_mem_read  in  1  EX instruction is a load.
- id_ex_rd  in  REG_AW  EX destination.
- id_ex_mem_access  in  1  EX instruction is a load or store.
- ex_mem_wen  in  1  MEM instruction is a store.
- ex_mem_mask_mode  in  2  MEM store size; 2'b10 = word.
- ex_mem_mem_read  in  1  MEM instruction is a load.
- ex_taken  in  1  EX branch/jump redirect.
- pc_from_taken, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  pipeline controls.
- busy  out  1  FSM not in S_IDLE.
- stall_cnt  out  CNT_W  cycles with pc_stall=1.

Function
REQ-007 SHALL implement FSM states S_IDLE, S_RMW, S_MWAIT with a down-counter cnt wide enough for max(RMW_LAT, MEM_WAIT).
REQ-008 SHALL drive every control output 0 unless a rule below sets it; outputs are combinational from state and inputs.
REQ-009 Load-use (S_IDLE only): SHALL fire when id_ex_mem_read=1, id_ex_rd!=0, and for some i, id_rs_used[i]=1 and rs[i]==id_ex_rd; drives pc_stall, if_id_stall, id_ex_flush = 1.
REQ-010 RMW (S_IDLE): SHALL fire when id_ex_mem_access & ex_mem_wen & ex_mem_mask_mode!=2'b10; drives pc_stall, if_id_stall, id_ex_stall, ex_mem_flush = 1; if RMW_LAT>1, next state S_RMW with cnt=RMW_LAT-1.
REQ-011 S_RMW SHALL repeat the REQ-010 pattern each cycle, decrement cnt, and return to S_IDLE when cnt reaches 1, giving exactly RMW_LAT stall cycles.
REQ-012 Memory wait (S_IDLE): when MEM_WAIT>0 and ex_mem_mem_read=1, SHALL drive pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1, with no flush; next state S_MWAIT with cnt=MEM_WAIT-1, or stay in S_IDLE if MEM_WAIT=1.
REQ-013 S_MWAIT SHALL hold the REQ-012 pattern until cnt reaches 1, then return to S_IDLE; total MEM_WAIT stall cycles.
REQ-014 Redirect (S_IDLE): ex_taken=1 SHALL drive pc_from_taken, if_id_flush, id_ex_flush = 1 and pc_stall, ex_mem_flush = 0.
REQ-015 Priority in S_IDLE SHALL be memory wait > redirect > RMW > load-use; a lower-priority rule is fully suppressed.
REQ-016 In S_RMW/S_MWAIT, ex_taken SHALL be ignored; it is honoured in the first S_IDLE cycle, since the stalled EX holds it stable.
REQ-017 stall_cnt SHALL increment by 1 each cycle with pc_stall=1, saturating at all-ones.
REQ-018 busy SHALL equal (state!=S_IDLE).
REQ-019 A register address of 0 SHALL never cause a load-use hazard.

Reset
REQ-020 When rst=1 at a rising edge, SHALL set state to S_IDLE, cnt to 0, and stall_cnt to 0, aborting any RMW or wait in progress.
REQ-021 While rst=1, all control outputs and busy SHALL be 0.

Structure
REQ-022 The state encoding, word mask value 2'b10, and register-address width SHALL live in the shared pipeline package.
REQ-023 The source comparison SHALL be a sub-module hazard_src_match (NUM_SRC, REG_AW), outputting a 1-bit match.

Verification
REQ-024 id_rs={rs2=5,rs1=3}, used=2'b11, id_ex_mem_read=1, id_ex_rd=3 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1; with id_ex_rd=0 -> no stall.
REQ-025 RMW_LAT=3, sh in MEM (mask 2'b01), load in EX -> 3 cycles of pc_stall/id_ex_stall/ex_mem_flush, busy=1 for cycles 2-3, then S_IDLE.
REQ-026 MEM_WAIT=2, load in MEM, ex_taken=1 simultaneously -> 2 cycles of ex_mem_stall with no flush, then pc_from_taken=if_id_flush=id_ex_flush=1.
REQ-027 ex_taken=1 with an RMW condition in the same cycle -> redirect pattern only, ex_mem_flush=0, state stays S_IDLE.
REQ-028 rst asserted in the middle of S_MWAIT -> next cycle state S_IDLE, stall_cnt=0, all outputs 0.
REQ-029 CNT_W=4, 20 consecutive stall cycles -> stall_cnt saturates and holds at 15.
